register_file: RTL and testbench

REGISTER_FILE -- requirements
Module: register_file

---
 rtl/register_file.sv | 62 ++++++
 tb/tb_register_file.sv | 168 ++++++++++++++++
 2 files changed

// File: rtl/register_file.sv
// register_file: 2**ADDR_W x DATA_W register file, two read ports and one write port; x0 is hardwired to zero.
// Latency: reads are combinational (0 cycles); a write lands on the rising clk edge and is readable after it.
// Backpressure: none; a write is accepted on every edge where we=1. Synchronous active-high rst clears all registers.
// Optional feature: define REGFILE_WR_BYPASS_EN to forward wd to a read port whose address matches a pending write.
module register_file #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic [ADDR_W-1:0] rs1,
  input  logic [ADDR_W-1:0] rs2,
  input  logic [ADDR_W-1:0] rd,
  input  logic [DATA_W-1:0] wd,
  output logic [DATA_W-1:0] read1,
  output logic [DATA_W-1:0] read2
);

  localparam int NREG = 2 ** ADDR_W;

  logic [DATA_W-1:0] regs [0:NREG-1];

  // A write to x0 is dropped here so that x0 never holds anything but zero.
  logic wr_vld;
  assign wr_vld = we && (rd != '0);

  // Register array update: reset clears everything and wins over a write.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NREG; i++) begin
        regs[i] <= '0;
      end
    end else if (wr_vld) begin
      regs[rd] <= wd;
    end
  end

  // Read muxes: x0 is forced to zero; optionally forward the pending write data.
  always_comb begin
    read1 = '0;
    read2 = '0;
    if (rs1 != '0) begin
      read1 = regs[rs1];
    end
    if (rs2 != '0) begin
      read2 = regs[rs2];
    end
`ifdef REGFILE_WR_BYPASS_EN
    // wr_vld already excludes rd=0, so x0 is never forwarded.
    if (wr_vld && (rs1 == rd)) begin
      read1 = wd;
    end
    if (wr_vld && (rs2 == rd)) begin
      read2 = wd;
    end
`else
    // Stored contents only: a same-cycle write is seen after the edge.
`endif
  end

endmodule

// File: tb/tb_register_file.sv
// Directed bench for register_file at default parameters (32 x 32 bits).
// Inputs change 1 time unit after a rising edge; outputs are checked before the next edge.
// Expectations for the same-cycle write/read case follow the REGFILE_WR_BYPASS_EN build setting.
module tb_register_file;

  localparam int DATA_W = 32;
  localparam int ADDR_W = 5;

  logic              clk;
  logic              rst;
  logic              we;
  logic [ADDR_W-1:0] rs1;
  logic [ADDR_W-1:0] rs2;
  logic [ADDR_W-1:0] rd;
  logic [DATA_W-1:0] wd;
  logic [DATA_W-1:0] read1;
  logic [DATA_W-1:0] read2;

  int checks = 0;
  int errors = 0;

  register_file #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
    .clk   (clk),
    .rst   (rst),
    .we    (we),
    .rs1   (rs1),
    .rs2   (rs2),
    .rd    (rd),
    .wd    (wd),
    .read1 (read1),
    .read2 (read2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one rising edge and settle past it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [DATA_W-1:0] obs, input logic [DATA_W-1:0] exp);
    checks++;
    assert (obs === exp)
      else begin
        errors++;
        $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
  endtask

  initial begin
    logic [DATA_W-1:0] bypass_exp;
    logic [ADDR_W-1:0] a;

    rst = 1'b1;
    we  = 1'b0;
    rs1 = '0;
    rs2 = '0;
    rd  = '0;
    wd  = '0;

    // Two reset edges, then release.
    tick();
    tick();
    rst = 1'b0;
    rs1 = 5'd1;
    rs2 = 5'd2;
    #1;
    check("reset_read1_x1", read1, 32'h0000_0000);
    check("reset_read2_x2", read2, 32'h0000_0000);

    // Every register reads zero after reset, on both ports.
    for (int i = 0; i < 32; i++) begin
      a   = ADDR_W'(i);
      rs1 = a;
      rs2 = ~a;
      #1;
      check($sformatf("reset_all_p1_x%0d", i), read1, 32'h0);
      check($sformatf("reset_all_p2_x%0d", 31 - i), read2, 32'h0);
    end

    // Write x1 and read it on both ports.
    we = 1'b1; rd = 5'd1; wd = 32'hAAAA_AAAA;
    tick();
    we = 1'b0; rs1 = 5'd1; rs2 = 5'd1;
    #1;
    check("x1_read1", read1, 32'hAAAA_AAAA);
    check("x1_read2", read2, 32'hAAAA_AAAA);

    // A pending x0 write is never visible, not even forwarded.
    we = 1'b1; rd = 5'd0; wd = 32'hFFFF_FFFF; rs1 = 5'd0; rs2 = 5'd0;
    #1;
    check("x0_pending_read1", read1, 32'h0);
    check("x0_pending_read2", read2, 32'h0);
    tick();
    we = 1'b0;
    #1;
    check("x0_after_read1", read1, 32'h0);
    check("x0_after_read2", read2, 32'h0);

    // Write x5, read x5 and x1 on independent ports.
    we = 1'b1; rd = 5'd5; wd = 32'h1234_5678;
    tick();
    we = 1'b0; rs1 = 5'd5; rs2 = 5'd1;
    #1;
    check("x5_read1", read1, 32'h1234_5678);
    check("x1_read2", read2, 32'hAAAA_AAAA);

    // Same-cycle write and read of x5.
`ifdef REGFILE_WR_BYPASS_EN
    bypass_exp = 32'hDEAD_BEEF;
`else
    bypass_exp = 32'h1234_5678;
`endif
    we = 1'b1; rd = 5'd5; wd = 32'hDEAD_BEEF; rs1 = 5'd5; rs2 = 5'd1;
    #1;
    check("samecyc_before_read1", read1, bypass_exp);
    check("samecyc_other_read2", read2, 32'hAAAA_AAAA);
    tick();
    we = 1'b0;
    #1;
    check("samecyc_after_read1", read1, 32'hDEAD_BEEF);

    // we=0 leaves state alone even with rd/wd active.
    rd = 5'd1; wd = 32'h1111_1111; rs1 = 5'd1; rs2 = 5'd5;
    tick();
    #1;
    check("we0_x1", read1, 32'hAAAA_AAAA);
    check("we0_x5", read2, 32'hDEAD_BEEF);

    // Highest address.
    we = 1'b1; rd = 5'd31; wd = 32'h0F0F_0F0F;
    tick();
    we = 1'b0; rs1 = 5'd31; rs2 = 5'd30;
    #1;
    check("x31_read1", read1, 32'h0F0F_0F0F);
    check("x30_read2", read2, 32'h0);

    // rst raised between edges with a write to x3: nothing changes before the edge.
    rst = 1'b1; we = 1'b1; rd = 5'd3; wd = 32'h5555_5555; rs1 = 5'd5; rs2 = 5'd1;
    #1;
    check("rst_midcyc_x5", read1, 32'hDEAD_BEEF);
    check("rst_midcyc_x1", read2, 32'hAAAA_AAAA);
    tick();
    rst = 1'b0; we = 1'b0;
    rs1 = 5'd1; rs2 = 5'd3;
    #1;
    check("rst_clr_x1", read1, 32'h0);
    check("rst_drop_x3", read2, 32'h0);
    rs1 = 5'd5; rs2 = 5'd31;
    #1;
    check("rst_clr_x5", read1, 32'h0);
    check("rst_clr_x31", read2, 32'h0);

    // Writes work again after reset.
    we = 1'b1; rd = 5'd3; wd = 32'hC3C3_3C3C;
    tick();
    we = 1'b0; rs1 = 5'd3; rs2 = 5'd3;
    #1;
    check("post_rst_x3_read1", read1, 32'hC3C3_3C3C);
    check("post_rst_x3_read2", read2, 32'hC3C3_3C3C);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
